framebuffer_reader: RTL and testbench
=====================================

FRAMEBUFFER_READER -- requirements
Module: framebuffer_reader

Interface
REQ-001 The block SHALL have parameter H_RES, default 240, pixels per line.
REQ-002 The block SHALL have parameter V_RES, default 320, lines per frame.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of two, at least 4).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: when low, frame starts are ignored.
REQ-007 The block SHALL have port base_addr, input, 32 bits: byte address of the frame, sampled at frame start.
REQ-008 The block SHALL have port frame_sync, input, 1 bit: one-cycle pulse from the LCD controller requesting a new frame.
REQ-009 The block SHALL have the following Avalon-MM read-master ports:
- avm_address, output, 32 bits;
- avm_read, output, 1 bit;
- avm_waitrequest, input, 1 bit;
- avm_readdata, input, 16 bits;
- avm_readdatavalid, input, 1 bit.
REQ-010 The block SHALL have the following pixel-stream ports to the LCD controller:
- pixel_data, output, 16 bits: RGB565;
- pixel_valid, output, 1 bit;
- pixel_ready, input, 1 bit.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port underrun, output, 1 bit: sticky; set when pixel_ready is high, the FIFO is empty and the state is FETCH; cleared by reset or by a frame start.

Function
REQ-013 The FSM SHALL have the states IDLE, FETCH, DRAIN and FLUSH.
REQ-014 IDLE -> FETCH when frame_sync && enable:
- load addr_q <= base_addr;
- clear issue_cnt and the FIFO.
REQ-015 In FETCH, the block SHALL assert avm_read with avm_address = addr_q when (in_flight + fifo_count) < FIFO_DEPTH; this credit rule guarantees the FIFO never overflows.
REQ-016 Once asserted, avm_read and avm_address SHALL hold stable while avm_waitrequest is high.
REQ-017 A read is accepted when avm_read && !avm_waitrequest. On acceptance:
- addr_q += 2 (byte addressing, 32-bit wrap);
- issue_cnt += 1;
- in_flight += 1.
REQ-018 avm_read SHALL stay asserted back-to-back across accepts while credit remains (one read per cycle maximum).
REQ-019 Each avm_readdatavalid SHALL decrement in_flight and, outside FLUSH, write avm_readdata into the FIFO.
- A same-cycle accept and return leaves in_flight unchanged.
REQ-020 FETCH -> DRAIN when the read that makes issue_cnt == H_RES*V_RES is accepted.
REQ-021 DRAIN -> IDLE when in_flight == 0 and the FIFO is empty.
- DRAIN issues no reads.
REQ-022 The FIFO SHALL be first-word-fall-through:
- pixel_valid = !fifo_empty && state != FLUSH;
- pixel_data = head entry;
- one entry pops per cycle with pixel_valid && pixel_ready.
REQ-023 Pixels SHALL be delivered in ascending address order, exactly H_RES*V_RES per frame, with none duplicated or dropped.
REQ-024 The first pixel_valid SHALL occur no earlier than 1 cycle after the first avm_readdatavalid.
- Latency from frame_sync to the first avm_read is 1 cycle.
REQ-025 frame_sync in FETCH or DRAIN (abort) SHALL enter FLUSH.
- A read held under waitrequest completes its handshake first; no new read is issued afterwards.
- The FIFO is cleared.
- Returns are discarded until in_flight == 0.
REQ-026 FLUSH -> FETCH with a freshly sampled base_addr when in_flight == 0 and no read is pending.
- A frame_sync during FLUSH is absorbed.
REQ-027 A frame_sync with enable low SHALL be ignored in IDLE; in other states it still aborts.
- Deasserting enable mid-frame does not stop the frame.
REQ-028 A FIFO pop and push in the same cycle SHALL both take effect, including when fifo_count == FIFO_DEPTH or fifo_count == 0.
REQ-029 in_flight SHALL be clog2(FIFO_DEPTH)+1 bits wide; issue_cnt and the pixel counters SHALL be wide enough for H_RES*V_RES without wrap.

Reset
REQ-030 On reset the block SHALL:
- enter IDLE;
- clear addr_q, issue_cnt, in_flight, the FIFO and underrun;
- drive avm_read=0, avm_address=0, pixel_valid=0, pixel_data=0, busy=0.
REQ-031 Reset mid-operation SHALL take precedence over all other events.
- Read data arriving after reset (for reads in flight before it) is discarded.
- That data is not counted.

Verification (H_RES=4, V_RES=2, FIFO_DEPTH=4)
REQ-032 Nominal frame: base_addr=0x1000, memory holding word k at 0x1000+2k, zero-wait slave, 2-cycle read latency, pixel_ready=1 -> pixels 0..7 in order, addresses 0x1000..0x100E, then busy falls.
REQ-033 Backpressure: pixel_ready=0 for 20 cycles -> at most 4 outstanding-plus-buffered, no FIFO overflow, all 8 pixels delivered after release.
REQ-034 Waitrequest: slave holds waitrequest for 3 cycles per read -> avm_address stable during the stall, no duplicate or skipped address.
REQ-035 Abort: frame_sync after pixel 3 with 2 reads in flight and base_addr=0x2000 -> stale returns discarded, next pixel_data comes from 0x2000, pixel_valid low throughout FLUSH.
REQ-036 Underrun: 10-cycle read latency with pixel_ready=1 -> underrun=1, sticky until the next frame start.
REQ-037 Reset during FETCH with 2 reads in flight -> all outputs at reset values next cycle, late readdatavalid ignored, and a subsequent frame is correct.

Source files
------------

// File: rtl/framebuffer_reader_if.sv
// rtl/framebuffer_reader_if.sv - Avalon-MM read master and pixel stream bundle
interface framebuffer_reader_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output pixel_data, pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  pixel_data, pixel_valid,
    output pixel_ready
  );
endinterface

// File: rtl/framebuffer_reader.sv
// rtl/framebuffer_reader.sv - Frame fetcher: Avalon-MM reads into a first-word-fall-through pixel FIFO
// Reads are issued only while in-flight reads plus buffered pixels leave FIFO room.
module framebuffer_reader #(
  parameter int H_RES      = 240,
  parameter int V_RES      = 320,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [31:0]          base_addr,
  input  logic                 frame_sync,
  framebuffer_reader_if.master bus,
  output logic                 busy,
  output logic                 underrun
);
  localparam int NPIX = H_RES * V_RES;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int FW   = AW + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);
  localparam logic [FW:0]   DEPTH    = (FW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [FW-1:0]   in_flight_q, in_flight_d;
  logic            hold_q, hold_d;
  logic            underrun_q, underrun_d;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]   count_q, count_d;

  logic            fifo_empty, credit, rd_req, accept, ret, push, pop;
  logic            fifo_clr, start;
  logic [FW:0]     committed;

  assign fifo_empty = (count_q == '0);
  assign committed  = {1'b0, in_flight_q} + {1'b0, count_q};
  assign credit     = (committed < DEPTH);
  // A stalled read stays asserted even after an abort moves the state to FLUSH.
  assign rd_req     = hold_q || (state_q == FETCH && credit);
  assign accept     = rd_req && !bus.avm_waitrequest;
  // Returns with nothing outstanding belong to reads issued before a reset.
  assign ret        = bus.avm_readdatavalid && (in_flight_q != '0);
  assign push       = ret && (state_q != FLUSH);
  assign pop        = bus.pixel_valid && bus.pixel_ready;

  assign bus.avm_read    = rd_req;
  assign bus.avm_address = rd_req ? addr_q : 32'h0;
  assign bus.pixel_valid = !fifo_empty && (state_q != FLUSH);
  assign bus.pixel_data  = bus.pixel_valid ? mem_q[rd_ptr_q] : 16'h0;
  assign busy            = (state_q != IDLE);
  assign underrun        = underrun_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    hold_d      = rd_req && bus.avm_waitrequest;
    fifo_clr    = 1'b0;
    start       = 1'b0;

    if (accept) begin
      addr_d      = addr_q + 32'd2;
      issue_cnt_d = issue_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE:  if (frame_sync && enable) start = 1'b1;
      FETCH: begin
        if (frame_sync) begin
          state_d  = FLUSH;
          fifo_clr = 1'b1;
        end else if (accept && issue_cnt_q == LAST_IDX) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_sync) begin
          state_d  = FLUSH;
          fifo_clr = 1'b1;
        end else if (in_flight_q == '0 && fifo_empty) begin
          state_d = IDLE;
        end
      end
      FLUSH: if (in_flight_q == '0 && !hold_q) start = 1'b1;
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d     = FETCH;
      addr_d      = base_addr;
      issue_cnt_d = '0;
      fifo_clr    = 1'b1;
    end
  end

  always_comb begin
    case ({accept, ret})
      2'b10:   in_flight_d = in_flight_q + 1'b1;
      2'b01:   in_flight_d = in_flight_q - 1'b1;
      default: in_flight_d = in_flight_q;
    endcase

    underrun_d = underrun_q;
    if (start)
      underrun_d = 1'b0;
    else if (state_q == FETCH && bus.pixel_ready && fifo_empty)
      underrun_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      in_flight_q <= '0;
      hold_q      <= 1'b0;
      underrun_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      in_flight_q <= in_flight_d;
      hold_q      <= hold_d;
      underrun_q  <= underrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push && !fifo_clr)
      mem_q[wr_ptr_q] <= bus.avm_readdata;
  end
endmodule

// File: tb/tb_framebuffer_reader.sv
// tb/tb_framebuffer_reader.sv - Directed self-checking bench for framebuffer_reader
module tb_framebuffer_reader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        frame_sync = 1'b0;
  logic [31:0] base_addr = 32'h0;
  logic        busy, underrun;

  framebuffer_reader_if bus ();

  framebuffer_reader #(.H_RES(4), .V_RES(2), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .base_addr  (base_addr),
    .frame_sync (frame_sync),
    .bus        (bus),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
  } ret_t;

  ret_t        rq[$];
  ret_t        r_tmp;
  logic [31:0] addr_log[$];
  logic [15:0] pix_log[$];
  logic [31:0] prev_addr = 32'h0;
  int          cyc = 0, wcnt = 0, wait_n = 0, lat = 2;
  int          issued = 0, popped = 0, max_out = 0, stall_err = 0;
  bit          ready_en = 1'b1, prev_stall = 1'b0;
  int          errors = 0, checks = 0;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    logic [31:0] d;
    d = (a - 32'h1000) >> 1;
    return d[15:0];
  endfunction

  // Memory slave and pixel sink, evaluated on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    bus.pixel_ready       = ready_en;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = 16'h0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = rq[0].data;
      rq.delete(0);
    end
    if (bus.pixel_valid && ready_en) begin
      pix_log.push_back(bus.pixel_data);
      popped++;
    end
    if (bus.avm_read) begin
      if (prev_stall && bus.avm_address !== prev_addr) stall_err++;
      if (wcnt < wait_n) begin
        bus.avm_waitrequest = 1'b1;
        wcnt++;
        prev_stall = 1'b1;
        prev_addr  = bus.avm_address;
      end else begin
        bus.avm_waitrequest = 1'b0;
        wcnt       = 0;
        prev_stall = 1'b0;
        addr_log.push_back(bus.avm_address);
        r_tmp.due  = cyc + lat;
        r_tmp.data = mem_word(bus.avm_address);
        rq.push_back(r_tmp);
        issued++;
      end
    end else begin
      if (prev_stall) stall_err++;
      bus.avm_waitrequest = 1'b0;
      wcnt       = 0;
      prev_stall = 1'b0;
    end
    if (issued - popped > max_out) max_out = issued - popped;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_frame(input logic [31:0] base);
    pix_log.delete();
    addr_log.delete();
    issued  = 0;
    popped  = 0;
    max_out = 0;
    base_addr  = base;
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (bus.avm_read !== 1'b0) begin errors++; $display("FAIL reset_read got=%0b exp=0", bus.avm_read); end
    checks++; if (bus.avm_address !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.avm_address); end
    checks++; if (bus.pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_pvalid got=%0b exp=0", bus.pixel_valid); end
    checks++; if (bus.pixel_data !== 16'h0) begin errors++; $display("FAIL reset_pdata got=%h exp=0", bus.pixel_data); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%0b exp=0", underrun); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_enable();
    enable = 1'b0;
    start_frame(32'h1000);
    tick(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enable_busy got=%0b exp=0", busy); end
    checks++; if (addr_log.size() != 0) begin errors++; $display("FAIL enable_reads got=%0d exp=0", addr_log.size()); end
    enable = 1'b1;
  endtask

  task automatic test_nominal();
    int bad;
    wait_n = 0; lat = 2; ready_en = 1'b1;
    start_frame(32'h1000);
    checks++; if (bus.avm_read !== 1'b1) begin errors++; $display("FAIL nom_first_read got=%0b exp=1", bus.avm_read); end
    checks++; if (bus.avm_address !== 32'h1000) begin errors++; $display("FAIL nom_first_addr got=%h exp=1000", bus.avm_address); end
    wait_idle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nom_busy_falls got=%0b exp=0", busy); end
    bad = 0;
    for (int k = 0; k < pix_log.size(); k++) if (pix_log[k] !== 16'(k)) bad++;
    checks++; if (pix_log.size() != 8 || bad != 0) begin errors++; $display("FAIL nom_pixels got count=%0d bad=%0d exp count=8 bad=0", pix_log.size(), bad); end
    bad = 0;
    for (int k = 0; k < addr_log.size(); k++) if (addr_log[k] !== 32'h1000 + 32'(2 * k)) bad++;
    checks++; if (addr_log.size() != 8 || bad != 0) begin errors++; $display("FAIL nom_addrs got count=%0d bad=%0d exp count=8 bad=0", addr_log.size(), bad); end
  endtask

  task automatic test_backpressure();
    int bad;
    ready_en = 1'b0;
    start_frame(32'h1000);
    tick(20);
    checks++; if (addr_log.size() != 4) begin errors++; $display("FAIL bp_reads_stalled got=%0d exp=4", addr_log.size()); end
    checks++; if (pix_log.size() != 0) begin errors++; $display("FAIL bp_no_pixels got=%0d exp=0", pix_log.size()); end
    ready_en = 1'b1;
    wait_idle();
    checks++; if (max_out > 4) begin errors++; $display("FAIL bp_outstanding got=%0d exp<=4", max_out); end
    bad = 0;
    for (int k = 0; k < pix_log.size(); k++) if (pix_log[k] !== 16'(k)) bad++;
    checks++; if (pix_log.size() != 8 || bad != 0) begin errors++; $display("FAIL bp_pixels got count=%0d bad=%0d exp count=8 bad=0", pix_log.size(), bad); end
  endtask

  task automatic test_waitrequest();
    int bad;
    wait_n = 3; stall_err = 0;
    start_frame(32'h1000);
    wait_idle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy got=%0b exp=0", busy); end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL wr_addr_stable got=%0d exp=0", stall_err); end
    bad = 0;
    for (int k = 0; k < addr_log.size(); k++) if (addr_log[k] !== 32'h1000 + 32'(2 * k)) bad++;
    checks++; if (addr_log.size() != 8 || bad != 0) begin errors++; $display("FAIL wr_addrs got count=%0d bad=%0d exp count=8 bad=0", addr_log.size(), bad); end
    bad = 0;
    for (int k = 0; k < pix_log.size(); k++) if (pix_log[k] !== 16'(k)) bad++;
    checks++; if (pix_log.size() != 8 || bad != 0) begin errors++; $display("FAIL wr_pixels got count=%0d bad=%0d exp count=8 bad=0", pix_log.size(), bad); end
    wait_n = 0;
  endtask

  task automatic test_abort();
    int bad, n_old, a_old, flush_valid;
    wait_n = 0; lat = 2; ready_en = 1'b1;
    start_frame(32'h1000);
    for (int i = 0; i < 100 && pix_log.size() < 4; i++) tick(1);
    base_addr  = 32'h2000;
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
    n_old = pix_log.size();
    a_old = addr_log.size();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got=%0b exp=1", busy); end
    flush_valid = 0;
    for (int i = 0; i < 20 && !bus.avm_read; i++) begin
      if (bus.pixel_valid) flush_valid++;
      tick(1);
    end
    checks++; if (flush_valid != 0) begin errors++; $display("FAIL abort_flush_valid got=%0d exp=0", flush_valid); end
    wait_idle();
    bad = 0;
    for (int k = 0; k < n_old; k++) if (pix_log[k] !== 16'(k)) bad++;
    checks++; if (n_old < 4 || n_old > 7 || bad != 0) begin errors++; $display("FAIL abort_old_pixels got count=%0d bad=%0d exp count 4..7 bad=0", n_old, bad); end
    bad = 0;
    for (int k = n_old; k < pix_log.size(); k++) if (pix_log[k] !== 16'h0800 + 16'(k - n_old)) bad++;
    checks++; if (pix_log.size() - n_old != 8 || bad != 0) begin errors++; $display("FAIL abort_new_pixels got count=%0d bad=%0d exp count=8 bad=0", pix_log.size() - n_old, bad); end
    bad = 0;
    for (int k = a_old; k < addr_log.size(); k++) if (addr_log[k] !== 32'h2000 + 32'(2 * (k - a_old))) bad++;
    checks++; if (addr_log.size() - a_old != 8 || bad != 0) begin errors++; $display("FAIL abort_new_addrs got count=%0d bad=%0d exp count=8 bad=0", addr_log.size() - a_old, bad); end
  endtask

  task automatic test_underrun();
    int bad;
    wait_n = 0; lat = 10; ready_en = 1'b1;
    start_frame(32'h1000);
    tick(5);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set got=%0b exp=1", underrun); end
    wait_idle();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky got=%0b exp=1", underrun); end
    bad = 0;
    for (int k = 0; k < pix_log.size(); k++) if (pix_log[k] !== 16'(k)) bad++;
    checks++; if (pix_log.size() != 8 || bad != 0) begin errors++; $display("FAIL ur_pixels got count=%0d bad=%0d exp count=8 bad=0", pix_log.size(), bad); end
    lat = 2; ready_en = 1'b0;
    start_frame(32'h1000);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear_on_start got=%0b exp=0", underrun); end
    tick(3);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_stays_clear got=%0b exp=0", underrun); end
    ready_en = 1'b1;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int bad, stray;
    wait_n = 0; lat = 2; ready_en = 1'b1;
    start_frame(32'h1000);
    tick(2);
    reset = 1'b1;
    tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%0b exp=0", busy); end
    checks++; if (bus.avm_read !== 1'b0 || bus.avm_address !== 32'h0) begin errors++; $display("FAIL rm_read got read=%0b addr=%h exp 0/0", bus.avm_read, bus.avm_address); end
    checks++; if (bus.pixel_valid !== 1'b0 || bus.pixel_data !== 16'h0) begin errors++; $display("FAIL rm_pixel got valid=%0b data=%h exp 0/0", bus.pixel_valid, bus.pixel_data); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rm_underrun got=%0b exp=0", underrun); end
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.pixel_valid || busy) stray++;
      tick(1);
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rm_late_data got=%0d exp=0", stray); end
    start_frame(32'h1000);
    wait_idle();
    bad = 0;
    for (int k = 0; k < pix_log.size(); k++) if (pix_log[k] !== 16'(k)) bad++;
    checks++; if (pix_log.size() != 8 || bad != 0) begin errors++; $display("FAIL rm_next_frame got count=%0d bad=%0d exp count=8 bad=0", pix_log.size(), bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_enable();
    test_nominal();
    test_backpressure();
    test_waitrequest();
    test_abort();
    test_underrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
